pushpop_seq: RTL and testbench

Multi-cycle sequencer for the register-list PUSH and POP instructions produced by the decoder.
- Accepts a decoded opcode and 8-bit register list, and holds the pipeline with `busy`.
- Issues one word memory transfer per listed register (R0–R7) over a valid/ready memory port.
- Drives register-file reads (PUSH) or writes (POP), then writes back the updated stack pointer.

---
 rtl/pushpop_pkg.sv | 26 ++
 rtl/pushpop_lsb_sel.sv | 24 ++
 rtl/pushpop_seq.sv | 157 +++++++++++++++
 tb/tb_pushpop_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pushpop_pkg.sv
// Shared definitions for the PUSH/POP register-list sequencer.
// Opcodes, FSM state type, list width and a popcount helper.
package pushpop_pkg;

   localparam logic [4:0]  OP_PUSH    = 5'b01011;
   localparam logic [4:0]  OP_POP     = 5'b01010;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned LIST_W     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StXfer,
      StWb
   } pushpop_state_t;

   function automatic logic [3:0] popcount8(input logic [LIST_W-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < int'(LIST_W); i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/pushpop_lsb_sel.sv
// Lowest-set-bit encoder over the 8-bit register list.
// Returns the bit index, the list with that bit cleared, and a non-empty flag.
module pushpop_lsb_sel
   import pushpop_pkg::*;
(
   input  logic [LIST_W-1:0] mask_i,
   output logic [2:0]        idx_o,
   output logic [LIST_W-1:0] rest_o,
   output logic              any_o
);

   always_comb begin
      idx_o = 3'd0;
      // Descending scan so the lowest set bit is the last one to win.
      for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = 3'(i);
         end
      end
      rest_o = mask_i & (mask_i - 8'd1);
      any_o  = |mask_i;
   end

endmodule

// File: rtl/pushpop_seq.sv
// Multi-cycle PUSH/POP sequencer: one word transfer per listed register, then SP writeback.
// Define PUSHPOP_EMPTY_FAULT_EN to turn an empty register list into an err pulse instead of a NOP.
module pushpop_seq
   import pushpop_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        opcode,
   input  logic [LIST_W-1:0] reglist,
   input  logic [ADDR_W-1:0] sp_in,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [2:0]        rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              rf_we,
   output logic [2:0]        rf_wr_addr,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              sp_we,
   output logic [ADDR_W-1:0] sp_wdata
);

   pushpop_state_t    state_q;
   logic              push_q;
   logic [LIST_W-1:0] mask_q;
   logic [ADDR_W-1:0] sp_q;
   logic [ADDR_W-1:0] newsp_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              sp_we_q;
   logic [ADDR_W-1:0] sp_wdata_q;
   logic              done_q;
   logic              err_q;

   logic [2:0]        cur_idx;
   logic [LIST_W-1:0] mask_rest;
   logic              mask_any;

   logic [3:0]        cnt;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] newsp;

   pushpop_lsb_sel u_lsb_sel (
      .mask_i (mask_q),
      .idx_o  (cur_idx),
      .rest_o (mask_rest),
      .any_o  (mask_any)
   );

   // Block base and final SP; full-descending stack, lowest register at lowest address.
   always_comb begin
      cnt   = popcount8(mask_q);
      span  = ADDR_W'(cnt) * ADDR_W'(WORD_BYTES);
      base  = push_q ? (sp_q - span) : sp_q;
      newsp = push_q ? base : (sp_q + span);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         push_q     <= 1'b0;
         mask_q     <= '0;
         sp_q       <= '0;
         newsp_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         sp_we_q    <= 1'b0;
         sp_wdata_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         sp_we_q <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start && ((opcode == OP_PUSH) || (opcode == OP_POP))) begin
                  push_q  <= (opcode == OP_PUSH);
                  mask_q  <= reglist;
                  sp_q    <= sp_in;
                  state_q <= StCalc;
               end
            end
            StCalc: begin
               newsp_q <= newsp;
               if (mask_any) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= push_q;
                  mem_addr_q <= base;
                  state_q    <= StXfer;
               end else begin
`ifdef PUSHPOP_EMPTY_FAULT_EN
                  err_q      <= 1'b1;
`else
                  done_q     <= 1'b1;
                  sp_we_q    <= 1'b1;
                  sp_wdata_q <= newsp;
`endif
                  state_q    <= StWb;
               end
            end
            StXfer: begin
               if (mem_ready) begin
                  mask_q     <= mask_rest;
                  mem_addr_q <= mem_addr_q + ADDR_W'(WORD_BYTES);
                  if (!(|mask_rest)) begin
                     mem_req_q  <= 1'b0;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= '0;
                     done_q     <= 1'b1;
                     sp_we_q    <= 1'b1;
                     sp_wdata_q <= newsp_q;
                     state_q    <= StWb;
                  end
               end
            end
            StWb: begin
               sp_wdata_q <= '0;
               state_q    <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = done_q;
   assign err      = err_q;
   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign sp_we    = sp_we_q;
   assign sp_wdata = sp_wdata_q;

   // Data paths pass straight through; indices are gated so idle outputs stay at zero.
   assign rf_rd_addr = (mem_req_q && mem_we_q) ? cur_idx : 3'd0;
   assign mem_wdata  = (mem_req_q && mem_we_q) ? rf_rd_data : '0;
   assign rf_we      = mem_req_q && !mem_we_q && mem_ready;
   assign rf_wr_addr = rf_we ? cur_idx : 3'd0;
   assign rf_wr_data = rf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_pushpop_seq.sv
// Self-checking bench for pushpop_seq: timeline/queue model plus literal checks.
// Honours PUSHPOP_EMPTY_FAULT_EN for the empty-list expectations.
module tb_pushpop_seq;
   import pushpop_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
`ifdef PUSHPOP_EMPTY_FAULT_EN
   localparam bit FAULT = 1'b1;
`else
   localparam bit FAULT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [4:0]    opcode = 5'd0;
   logic [7:0]    reglist = 8'd0;
   logic [AW-1:0] sp_in = '0;
   logic          busy, done, err, mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b1;
   logic [DW-1:0] mem_rdata;
   logic [2:0]    rf_rd_addr, rf_wr_addr;
   logic [DW-1:0] rf_rd_data, rf_wr_data;
   logic          rf_we, sp_we;
   logic [AW-1:0] sp_wdata;

   pushpop_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .reglist(reglist),
      .sp_in(sp_in), .busy(busy), .done(done), .err(err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .sp_we(sp_we), .sp_wdata(sp_wdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rfval(input logic [2:0] i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
   endfunction

   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   assign rf_rd_data = rfval(rf_rd_addr);
   assign mem_rdata  = memval(mem_addr);

   // Model of the operation in flight
   bit            op_active = 1'b0;
   bit            m_push = 1'b0;
   int            m_n = 0;
   int            m_end = 0;
   int            c0 = 0;
   logic [AW-1:0] m_sp = '0;
   logic [AW-1:0] q_addr[$];
   logic [2:0]    q_reg[$];
   int            wait_beat = 0, wait_n = 0, stall_cnt = 0;

   // Observations recorded for the literal checks
   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   int            seen_done_rel = 0, seen_err_rel = 0, seen_spwe = 0;
   logic [AW-1:0] seen_sp = '0;

   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, want);
      end
   endtask

   task automatic compare_cycle();
      int rel;
      bit e_req, e_fin, e_empty;
      rel     = cyc - c0 + 1;
      e_req   = op_active && (m_n > 0) && (rel >= 2) && (rel < m_end);
      e_fin   = op_active && (rel == m_end);
      e_empty = (m_n == 0);
      chk("busy", 32'(busy), 32'(op_active && rel >= 1 && rel <= m_end));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("done", 32'(done), 32'(e_fin && !(FAULT && e_empty)));
      chk("sp_we", 32'(sp_we), 32'(e_fin && !(FAULT && e_empty)));
      chk("err", 32'(err), 32'(e_fin && FAULT && e_empty));
      chk("rf_we", 32'(rf_we), 32'(e_req && !m_push && mem_ready));
      if (e_req && q_addr.size() > 0) begin
         chk("mem_addr", mem_addr, q_addr[0]);
         chk("mem_we", 32'(mem_we), 32'(m_push));
         if (m_push) chk("mem_wdata", mem_wdata, rfval(q_reg[0]));
         if (!m_push && mem_ready) begin
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(q_reg[0]));
            chk("rf_wr_data", rf_wr_data, memval(q_addr[0]));
         end
      end
      if (mem_req && mem_ready) begin
         log_addr.push_back(mem_addr);
         log_data.push_back(mem_we ? mem_wdata : rf_wr_data);
         if (q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_reg.pop_front());
         end
      end
      if (done) seen_done_rel = rel;
      if (err) seen_err_rel = rel;
      if (sp_we) begin
         seen_spwe++;
         seen_sp = sp_wdata;
         chk("sp_wdata", sp_wdata, m_sp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      #1;
      if (rst_n) compare_cycle();
   end

   // Memory handshake: stall the chosen beat for wait_n cycles, otherwise zero-wait.
   initial forever begin
      @(negedge clk);
      if (mem_req && (m_n - q_addr.size() + 1 == wait_beat) && (stall_cnt < wait_n)) begin
         mem_ready = 1'b0;
         stall_cnt++;
      end else begin
         mem_ready = 1'b1;
      end
   end

   task automatic run_op(input logic [4:0] opc, input logic [7:0] list, input logic [AW-1:0] sp,
                         input int wb, input int wn, input int restart_rel, input int rst_beat);
      logic [AW-1:0] base;
      int k;
      @(negedge clk);
      start = 1'b1; opcode = opc; reglist = list; sp_in = sp;
      wait_beat = wb; wait_n = wn; stall_cnt = 0;
      m_push = (opc == OP_PUSH);
      m_n    = $countones(list);
      base   = m_push ? sp - AW'(4 * m_n) : sp;
      m_sp   = m_push ? base : sp + AW'(4 * m_n);
      q_addr.delete(); q_reg.delete(); k = 0;
      for (int i = 0; i < 8; i++) begin
         if (list[i]) begin
            q_reg.push_back(3'(i));
            q_addr.push_back(base + AW'(4 * k));
            k++;
         end
      end
      m_end = m_n + 2 + (((m_n > 0) && (wb >= 1) && (wb <= m_n)) ? wn : 0);
      log_addr.delete(); log_data.delete();
      seen_done_rel = 0; seen_err_rel = 0; seen_spwe = 0; seen_sp = '0;
      @(posedge clk);
      #1;
      c0 = cyc;
      op_active = (opc == OP_PUSH) || (opc == OP_POP);
      start = 1'b0; opcode = 5'd0; reglist = 8'd0; sp_in = '0;
      if (!op_active) begin
         repeat (4) @(negedge clk);
         #2;
         return;
      end
      for (int r = 1; r <= m_end; r++) begin
         @(negedge clk);
         #2;
         if (r == restart_rel) begin
            start = 1'b1; opcode = OP_POP; reglist = 8'hFF; sp_in = 32'h0000_0100;
         end else begin
            start = 1'b0; opcode = 5'd0; reglist = 8'd0; sp_in = '0;
         end
         if (rst_beat > 0 && (m_n - q_addr.size() == rst_beat)) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            op_active = 1'b0;
            q_addr.delete(); q_reg.delete();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            #2;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_sp_wdata", sp_wdata, 32'd0);
            chk("rst_rf_we", 32'(rf_we), 32'd0);
            return;
         end
      end
      op_active = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_sp_we", 32'(sp_we), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_sp_wdata", sp_wdata, 32'd0);
      rst_n = 1'b1;

      // PUSH R0,R2 from SP 0x1000
      run_op(OP_PUSH, 8'b0000_0101, 32'h0000_1000, 0, 0, 0, 0);
      chk("t1_done_cycle", seen_done_rel, 32'd4);
      chk("t1_sp", seen_sp, 32'h0000_0FF8);
      chk("t1_beats", log_addr.size(), 32'd2);
      chk("t1_addr0", log_addr[0], 32'h0000_0FF8);
      chk("t1_addr1", log_addr[1], 32'h0000_0FFC);
      chk("t1_data1", log_data[1], 32'hC0DE_0222);

      // Back-to-back POP of all eight registers
      run_op(OP_POP, 8'hFF, 32'h0000_0F00, 0, 0, 0, 0);
      chk("t2_done_cycle", seen_done_rel, 32'd10);
      chk("t2_sp", seen_sp, 32'h0000_0F20);
      chk("t2_beats", log_addr.size(), 32'd8);
      chk("t2_addr7", log_addr[7], 32'h0000_0F1C);
      chk("t2_data7", log_data[7], 32'h0000_0F1C ^ 32'hA5A5_5A5A);

      // PUSH R1,R4,R7 with beat 2 stalled three cycles
      run_op(OP_PUSH, 8'b1001_0010, 32'h0000_2000, 2, 3, 0, 0);
      chk("t3_done_cycle", seen_done_rel, 32'd8);
      chk("t3_sp", seen_sp, 32'h0000_1FF4);
      chk("t3_addr1", log_addr[1], 32'h0000_1FF8);
      chk("t3_data1", log_data[1], 32'hC0DE_0444);

      // Empty list
      run_op(OP_PUSH, 8'h00, 32'h0000_1000, 0, 0, 0, 0);
`ifdef PUSHPOP_EMPTY_FAULT_EN
      chk("t4_err_cycle", seen_err_rel, 32'd2);
      chk("t4_no_sp_we", seen_spwe, 32'd0);
`else
      chk("t4_done_cycle", seen_done_rel, 32'd2);
      chk("t4_sp", seen_sp, 32'h0000_1000);
`endif

      // POP across the top of the address space
      run_op(OP_POP, 8'h11, 32'hFFFF_FFFC, 0, 0, 0, 0);
      chk("t5_addr1", log_addr[1], 32'h0000_0000);
      chk("t5_sp", seen_sp, 32'h0000_0004);
      chk("t5_done_cycle", seen_done_rel, 32'd4);

      // Non PUSH/POP opcode is ignored
      run_op(5'b00111, 8'hFF, 32'h0000_1000, 0, 0, 0, 0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_beats", log_addr.size(), 32'd0);

      // start while busy is ignored
      run_op(OP_PUSH, 8'b0111_0000, 32'h0000_5000, 0, 0, 2, 0);
      chk("t7_beats", log_addr.size(), 32'd3);
      chk("t7_sp", seen_sp, 32'h0000_4FF4);
      chk("t7_done_cycle", seen_done_rel, 32'd5);
      repeat (3) @(negedge clk);
      #2;
      chk("t7_idle_after", 32'(busy), 32'd0);

      // Reset after the first POP beat, then a fresh PUSH
      run_op(OP_POP, 8'h0F, 32'h0000_3000, 0, 0, 0, 1);
      chk("t8_no_sp_we", seen_spwe, 32'd0);
      chk("t8_beats", log_addr.size(), 32'd1);
      run_op(OP_PUSH, 8'b1000_0001, 32'h0000_4000, 0, 0, 0, 0);
      chk("t9_done_cycle", seen_done_rel, 32'd4);
      chk("t9_sp", seen_sp, 32'h0000_3FF8);
      chk("t9_data1", log_data[1], 32'hC0DE_0777);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
